dot_pair_issuer: RTL and testbench
==================================

// Module: dot_pair_issuer
// PURPOSE
//  Producer side of the accumulator handshake (data/ena in, flag/acc out) in the 32x32 matrix datapath.
//  Reads operand pairs a[i], b[i] from two operand RAMs and multiplies them in Q11.21 fixed point.
//  Streams products as data+ena in groups of TERMS, with the idle cycle the accumulator needs between groups.
//  Captures each finished sum (acc on flag) and writes it to the result RAM.
// PARAMETERS
//  W      32  data width, signed Q11.21 (bit 31 = sign, 21 fraction bits)
//  FRAC   21  fraction bits
//  TERMS  2   products per group; must equal the accumulator group size
//  AW     10  operand RAM address width
//  RW     9   result RAM address width
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous, active-high reset
//  start     in   1   1-cycle pulse; sampled only in IDLE
//  n_groups  in   16  number of groups to issue; sampled with start
//  busy      out  1   high from the cycle after start is accepted until the done cycle inclusive
//  done      out  1   1-cycle pulse when the last result is written
//  op_rd     out  1   operand read strobe to both RAMs
//  a_addr    out  AW  operand A address
//  b_addr    out  AW  operand B address; always equals a_addr
//  a_q       in   W   RAM A data; valid 1 cycle after op_rd
//  b_q       in   W   RAM B data; valid 1 cycle after op_rd
//  prod_data out  W   product to accumulator data
//  prod_ena  out  1   product valid, to accumulator ena
//  acc_flag  in   1   accumulator flag; its sum is valid on acc_in in the same cycle
//  acc_in    in   W   accumulator acc
//  res_we    out  1   result write strobe
//  res_addr  out  RW  result address; 0,1,2,... within a run
//  res_data  out  W   result data
//  err_ovf   out  1   sticky flag: a product saturated; cleared when start is accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; all counters 0. Reset mid-run aborts immediately and writes nothing more.
//  The accumulator's reset must be asserted together with rst.
//  FSM states: IDLE, ISSUE, GAP, DRAIN.
//   IDLE -> ISSUE on start with n_groups>0. On start with n_groups==0, pulse done the next cycle; no reads.
//   ISSUE: op_rd=1 for TERMS consecutive cycles; a_addr increments by 1 per read, starting at 0.
//   ISSUE -> GAP after the TERMS-th read.
//   GAP: one cycle with op_rd=0. Then ISSUE if groups remain, else DRAIN.
//   DRAIN: wait until results written == n_groups; then pulse done and go to IDLE.
//  Pipeline timing:
//   op_rd at cycle t -> a_q/b_q at t+1 -> registered prod_data/prod_ena at t+2.
//   prod_ena therefore repeats the op_rd pattern 1,1,0.
//   Accumulator flag follows at t+3 of the last term; res_we, res_data=acc_in and res_addr are registered 1 cycle after acc_flag.
//  Reference timeline (start at cycle 0, n_groups=1): op_rd at cycles 1-2; prod_ena at 3-4; acc_flag at 5; res_we and done at 6.
//  Multiply: 64b signed product (Q22.42). Result = bits [52:21], truncated toward -inf.
//   If bits [63:52] are not all equal, saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative) and set err_ovf.
//  Wrap-around: address arithmetic is modulo 2^AW; result addresses are modulo 2^RW. No error on wrap.
//  Ignored inputs:
//   start while busy.
//   acc_flag while not busy, or after n_groups results already written.
//  Simultaneous events: acc_flag and the last GAP cycle in the same cycle -> the write still occurs and DRAIN counts it.
//  Never assert prod_ena in the cycle after a group's last term; the accumulator drops data during its clear cycle.
// STRUCTURE
//  Package mat_fxp_pkg holds:
//   W, FRAC, TERMS constants
//   FXP_MAX = 32'h7FFFFFFF and FXP_MIN = 32'h80000000
//   FSM state encoding as localparams
//  Sub-module fxp_mul_sat: combinational W x W multiply with shift and saturation; outputs prod and ovf.
//  Top level holds: FSM, read counter, group counter, result counter, output registers.
// TESTING
//  1) n_groups=1; a={1.5, -1.0}={0x00300000, 0xFFE00000}; b={2.0, 0.5}={0x00400000, 0x00100000}
//     -> prod_data 0x00600000 then 0xFFF00000; res_data 0x00500000 at res_addr 0; done at cycle 6.
//  2) n_groups=4 back-to-back -> op_rd pattern 110110110110; 4 writes to addresses 0-3; done once; busy low after done.
//  3) a=512.0 (0x40000000), b=4.0 (0x00800000) -> prod_data 0x7FFFFFFF, err_ovf=1.
//     Next start clears err_ovf to 0.
//  4) n_groups=0 -> done 1 cycle after start; op_rd, prod_ena and res_we never assert.
//  5) rst asserted during the GAP of group 2 of 3 -> all outputs 0 next cycle; no further res_we.
//     A new start after reset runs from address 0.
//  6) start pulsed while busy, and acc_flag injected in IDLE -> no effect, no write, counters unchanged.

Source files
------------

// File: rtl/mat_fxp_pkg.sv
// ============================================================================
//  mat_fxp_pkg : shared Q11.21 constants and dot-pair issuer state encoding
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mat_fxp_pkg;

    localparam int W     = 32;
    localparam int FRAC  = 21;
    localparam int TERMS = 2;

    localparam logic [W-1:0] FXP_MAX = 32'h7FFF_FFFF;
    localparam logic [W-1:0] FXP_MIN = 32'h8000_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fxp_mul_sat.sv
// ============================================================================
//  fxp_mul_sat : combinational Q11.21 x Q11.21 multiply, floor-rounded, saturating
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fxp_mul_sat
    import mat_fxp_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] prod_o,
    output logic         ovf_o
);

    logic signed [2*W-1:0]    w_full;
    logic [W-FRAC:0]          w_guard;
    logic [FRAC-1:0]          w_unused_frac;
    logic                     w_fits;

    assign w_full        = $signed(a_i) * $signed(b_i);
    // The kept field is representable only if every bit above it copies its MSB.
    assign w_guard       = w_full[2*W-1:W+FRAC-1];
    assign w_unused_frac = w_full[FRAC-1:0];
    assign w_fits        = (&w_guard) | ~(|w_guard);

    always_comb begin
        prod_o = w_full[W+FRAC-1:FRAC];
        ovf_o  = 1'b0;
        if (!w_fits) begin
            ovf_o  = 1'b1;
            prod_o = w_full[2*W-1] ? FXP_MIN : FXP_MAX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dot_pair_issuer.sv
// ============================================================================
//  dot_pair_issuer : streams a[i]*b[i] products to the accumulator in groups
//                    and stores each finished group sum in the result RAM
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module dot_pair_issuer
    import mat_fxp_pkg::*;
#(
    parameter int AW = 10,
    parameter int RW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   n_groups,
    output logic          busy,
    output logic          done,
    output logic          op_rd,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    input  logic [W-1:0]  a_q,
    input  logic [W-1:0]  b_q,
    output logic [W-1:0]  prod_data,
    output logic          prod_ena,
    input  logic          acc_flag,
    input  logic [W-1:0]  acc_in,
    output logic          res_we,
    output logic [RW-1:0] res_addr,
    output logic [W-1:0]  res_data,
    output logic          err_ovf
);

    localparam int             TCW       = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [TCW-1:0] LAST_TERM = TCW'(TERMS - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   ngrp_q, ngrp_d;
    logic [15:0]   grp_q, grp_d;
    logic [15:0]   res_cnt_q, res_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TCW-1:0] term_q, term_d;
    logic          rd_d1_q;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [W-1:0]  prod_q;
    logic          prod_ena_q;
    logic          res_we_q;
    logic [RW-1:0] res_addr_q;
    logic [W-1:0]  res_data_q;

    logic          w_busy, w_accept, w_wr, w_ovf;
    logic [W-1:0]  w_prod;

    fxp_mul_sat u_mul (
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_o (w_prod),
        .ovf_o  (w_ovf)
    );

    // The done cycle still counts as busy, so a start landing on it is dropped.
    assign w_busy   = (state_q != S_IDLE) || done_q;
    assign w_accept = start && (state_q == S_IDLE) && !done_q;
    assign w_wr     = acc_flag && w_busy && (res_cnt_q < ngrp_q);

    always_comb begin
        state_d   = state_q;
        ngrp_d    = ngrp_q;
        grp_d     = grp_q;
        addr_d    = addr_q;
        term_d    = term_q;
        res_cnt_d = res_cnt_q + {15'd0, w_wr};
        done_d    = 1'b0;
        err_d     = err_q | (rd_d1_q & w_ovf);
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    ngrp_d    = n_groups;
                    grp_d     = '0;
                    addr_d    = '0;
                    term_d    = '0;
                    res_cnt_d = '0;
                    err_d     = 1'b0;
                    if (n_groups == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                addr_d = addr_q + 1'b1;
                if (term_q == LAST_TERM) begin
                    term_d  = '0;
                    grp_d   = grp_q + 16'd1;
                    state_d = S_GAP;
                end else begin
                    term_d = term_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = (grp_q != ngrp_q) ? S_ISSUE : S_DRAIN;
            end
            S_DRAIN: begin
                if (res_cnt_d == ngrp_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ngrp_q     <= '0;
            grp_q      <= '0;
            res_cnt_q  <= '0;
            addr_q     <= '0;
            term_q     <= '0;
            rd_d1_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            prod_q     <= '0;
            prod_ena_q <= 1'b0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ngrp_q     <= ngrp_d;
            grp_q      <= grp_d;
            res_cnt_q  <= res_cnt_d;
            addr_q     <= addr_d;
            term_q     <= term_d;
            rd_d1_q    <= (state_q == S_ISSUE);
            done_q     <= done_d;
            err_q      <= err_d;
            prod_ena_q <= rd_d1_q;
            if (rd_d1_q) begin
                prod_q <= w_prod;
            end
            res_we_q   <= w_wr;
            if (w_wr) begin
                res_addr_q <= res_cnt_q[RW-1:0];
                res_data_q <= acc_in;
            end
        end
    end

    assign busy      = w_busy;
    assign done      = done_q;
    assign op_rd     = (state_q == S_ISSUE);
    assign a_addr    = addr_q;
    assign b_addr    = addr_q;
    assign prod_data = prod_q;
    assign prod_ena  = prod_ena_q;
    assign res_we    = res_we_q;
    assign res_addr  = res_addr_q;
    assign res_data  = res_data_q;
    assign err_ovf   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_pair_issuer.sv
// ============================================================================
//  tb_dot_pair_issuer : operand RAM and accumulator models around the issuer
//  Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dot_pair_issuer;

    localparam int W     = 32;
    localparam int AW    = 10;
    localparam int RW    = 9;
    localparam int TERMS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   n_groups;
    logic          busy, done, op_rd, prod_ena, res_we, err_ovf;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_q, b_q, prod_data, res_data, acc_in;
    logic [RW-1:0] res_addr;
    logic          acc_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_pair_issuer #(.AW(AW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_groups  (n_groups),
        .busy      (busy),
        .done      (done),
        .op_rd     (op_rd),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_q       (a_q),
        .b_q       (b_q),
        .prod_data (prod_data),
        .prod_ena  (prod_ena),
        .acc_flag  (acc_flag),
        .acc_in    (acc_in),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .err_ovf   (err_ovf)
    );

    // Operand RAMs with one cycle of read latency
    logic [W-1:0] ram_a [0:(1<<AW)-1];
    logic [W-1:0] ram_b [0:(1<<AW)-1];

    initial begin
        a_q = '0;
        b_q = '0;
    end

    always @(posedge clk) begin
        if (op_rd) begin
            a_q <= ram_a[a_addr];
            b_q <= ram_b[b_addr];
        end
    end

    // Accumulator: sums TERMS products, raises flag with the sum the next cycle
    logic [W-1:0] m_sum, m_acc, inj_val;
    int           m_cnt;
    logic         m_flag, inj_flag;

    always @(posedge clk) begin
        if (rst) begin
            m_sum  <= '0;
            m_acc  <= '0;
            m_cnt  <= 0;
            m_flag <= 1'b0;
        end else begin
            m_flag <= 1'b0;
            if (prod_ena) begin
                if (m_cnt == TERMS - 1) begin
                    m_flag <= 1'b1;
                    m_acc  <= m_sum + prod_data;
                    m_sum  <= '0;
                    m_cnt  <= 0;
                end else begin
                    m_sum <= m_sum + prod_data;
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign acc_flag = m_flag | inj_flag;
    assign acc_in   = inj_flag ? inj_val : m_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Real-valued Q11.21 product: floor(a*b / 2^21), clamped to the 32-bit range
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            output bit ovf);
        longint p, q;
        p   = longint'($signed(a)) * longint'($signed(b));
        q   = p >>> 21;
        ovf = 1'b0;
        if (q > 64'sd2147483647) begin
            ovf = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (q < -64'sd2147483648) begin
            ovf = 1'b1;
            return 32'h8000_0000;
        end
        return q[31:0];
    endfunction

    task automatic fill_rams(input bit allow_big);
        int v;
        for (int i = 0; i < 64; i++) begin
            v = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
            ram_a[i] = (allow_big && $urandom_range(0, 3) == 0) ? $urandom : v;
            v = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
            ram_b[i] = (allow_big && $urandom_range(0, 3) == 0) ? $urandom : v;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, {prod_data, res_data}, 64'd0);
        chk({tag, "_ctl"}, {29'd0, busy, done, op_rd, a_addr, b_addr, prod_ena, res_we,
                            res_addr, err_ovf}, 64'd0);
    endtask

    // One complete run; xstart > 0 pulses an extra start in that cycle
    task automatic do_run(input int ng, input int xstart);
        logic [W-1:0] exp_p[$];
        logic [W-1:0] exp_r[$];
        logic [W-1:0] p, s;
        bit           o, eovf;
        bit [63:0]    rd_obs, rd_exp, pe_obs, pe_exp, bz_obs, bz_exp;
        int           exp_done, rd_idx, addr_err, pidx, widx, done_cnt, done_at;
        eovf = 1'b0;
        for (int g = 0; g < ng; g++) begin
            s = '0;
            for (int j = 0; j < TERMS; j++) begin
                p = fx_mul(ram_a[g*TERMS+j], ram_b[g*TERMS+j], o);
                exp_p.push_back(p);
                eovf |= o;
                s += p;
            end
            exp_r.push_back(s);
        end
        exp_done = (ng == 0) ? 1 : 3*ng + 3;
        rd_exp = '0; pe_exp = '0; bz_exp = '0;
        rd_obs = '0; pe_obs = '0; bz_obs = '0;
        for (int c = 1; c <= 3*ng; c++) begin
            if ((c - 1) % 3 != 2) begin
                rd_exp[c]   = 1'b1;
                pe_exp[c+2] = 1'b1;
            end
        end
        for (int c = 1; c <= exp_done; c++) bz_exp[c] = 1'b1;
        rd_idx = 0; addr_err = 0; pidx = 0; widx = 0; done_cnt = 0; done_at = -1;

        @(negedge clk);
        start    = 1'b1;
        n_groups = 16'(ng);
        for (int c = 1; c <= exp_done + 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                chk("err_ovf_cleared", {63'd0, err_ovf}, 64'd0);
            end
            rd_obs[c] = op_rd;
            pe_obs[c] = prod_ena;
            bz_obs[c] = busy;
            if (op_rd) begin
                if (a_addr !== AW'(rd_idx) || b_addr !== a_addr) addr_err++;
                rd_idx++;
            end
            if (prod_ena) begin
                if (pidx < exp_p.size()) chk("prod_data", {32'd0, prod_data}, {32'd0, exp_p[pidx]});
                pidx++;
            end
            if (res_we) begin
                if (widx < ng) begin
                    chk("res_addr", {55'd0, res_addr}, 64'(widx % (1 << RW)));
                    chk("res_data", {32'd0, res_data}, {32'd0, exp_r[widx]});
                end
                widx++;
            end
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (xstart > 0 && c == xstart) begin
                start    = 1'b1;
                n_groups = 16'd7;
            end else if (xstart > 0 && c == xstart + 1) begin
                start = 1'b0;
            end
        end
        chk("op_rd_pattern", rd_obs, rd_exp);
        chk("prod_ena_pattern", pe_obs, pe_exp);
        chk("busy_pattern", bz_obs, bz_exp);
        chk("addr_sequence", 64'(addr_err), 64'd0);
        chk("done_cycle", 64'(done_at), 64'(exp_done));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("write_count", 64'(widx), 64'(ng));
        chk("prod_count", 64'(pidx), 64'(TERMS*ng));
        chk("err_ovf", {63'd0, err_ovf}, {63'd0, eovf});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wcnt;
        rst = 1'b1; start = 1'b0; n_groups = '0; inj_flag = 1'b0; inj_val = '0;
        fill_rams(1'b0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed: 1.5*2.0 + (-1.0)*0.5 = 2.5
        ram_a[0] = 32'h0030_0000; ram_b[0] = 32'h0040_0000;
        ram_a[1] = 32'hFFE0_0000; ram_b[1] = 32'h0010_0000;
        do_run(1, 0);

        // Back-to-back groups
        do_run(4, 0);

        // 512.0 * 4.0 saturates; then a clean run clears the flag
        ram_a[0] = 32'h4000_0000; ram_b[0] = 32'h0080_0000;
        do_run(1, 0);
        fill_rams(1'b0);
        do_run(2, 0);

        // Zero groups
        do_run(0, 0);

        // Reset during the gap of group 2 of 3
        @(negedge clk);
        start = 1'b1; n_groups = 16'd3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst  = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_we) wcnt++;
        end
        chk("no_write_after_reset", 64'(wcnt), 64'd0);
        do_run(3, 0);

        // Stray accumulator flag while idle, then start pulsed mid-run
        @(negedge clk);
        inj_flag = 1'b1; inj_val = $urandom;
        @(negedge clk);
        inj_flag = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_we) wcnt++;
        end
        chk("idle_flag_ignored", 64'(wcnt), 64'd0);
        do_run(3, 5);

        // Randomised runs with occasional saturation
        for (int r = 0; r < 6; r++) begin
            fill_rams(1'b1);
            do_run(int'($urandom_range(1, 15)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
